// File: rtl/room_door_arbiter.sv
// Room occupancy arbiter: one room, N_DOORS entrance doors, a single shared
// occupancy budget. Grants one door at a time in round-robin order, counts
// entries through the granted door, and accepts exits on any door at any time.
// A person passing in through a door that is not open raises a sticky ALARM.

// Per-door lane: flags a pass-in through a closed door, forwards the exit pulse.
module room_door_lane (
  input  logic in_p,
  input  logic open_q,
  input  logic out_p,
  output logic bypass,
  output logic exit_p
);
  assign bypass = in_p & ~open_q;
  assign exit_p = out_p;
endmodule

module room_door_arbiter #(
  parameter int N_DOORS     = 4,
  parameter int CAP         = 15,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               T,
  input  logic [N_DOORS-1:0] ENT,
  input  logic [N_DOORS-1:0] IN,
  input  logic [N_DOORS-1:0] OUT,
  output logic [N_DOORS-1:0] OPEN,
  output logic               CLOSE,
  output logic [CNT_W-1:0]   COUNT,
  output logic               ALARM
);

  localparam int PTR_W = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;
  localparam int TMR_W = $clog2(OPEN_CYCLES + 1);
  // Wide enough for COUNT plus one entry minus up to N_DOORS exits, signed.
  localparam int SUM_W = CNT_W + $clog2(N_DOORS) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             st;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   g;
  logic [TMR_W-1:0]   timer;

  logic [N_DOORS-1:0] bypass_v;
  logic [N_DOORS-1:0] exit_v;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   g_inc;
  logic               entry;
  logic               grant_ok;
  logic               release_door;
  logic [SUM_W-1:0]   nexit;
  logic signed [SUM_W-1:0] nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // One lane per door for the closed-door bypass check and exit forwarding.
  genvar gi;
  generate
    for (gi = 0; gi < N_DOORS; gi++) begin : g_lane
      room_door_lane u_lane (
        .in_p   (IN[gi]),
        .open_q (OPEN[gi]),
        .out_p  (OUT[gi]),
        .bypass (bypass_v[gi]),
        .exit_p (exit_v[gi])
      );
    end
  endgenerate

  // Room is closed when full or outside visiting time.
  assign CLOSE = (COUNT == CNT_W'(CAP)) || !T;

  // Round-robin pick: first requesting door at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_DOORS; k++) begin
      int s;
      s = int'(ptr) + k;
      if (s >= N_DOORS) s = s - N_DOORS;
      if (!found && ENT[PTR_W'(s)]) begin
        found = 1'b1;
        pick  = PTR_W'(s);
      end
    end
  end

  // Grant/release decisions for the current cycle.
  always_comb begin
    g_inc        = (g == PTR_W'(N_DOORS - 1)) ? '0 : g + PTR_W'(1);
    grant_ok     = T && (COUNT < CNT_W'(CAP)) && found;
    // An entry only counts while visiting time is on; a T drop wins over IN.
    entry        = (st == GRANT) && T && IN[g];
    release_door = (st == GRANT) &&
                   (!T || IN[g] || (timer == TMR_W'(OPEN_CYCLES - 1)));
  end

  // Net occupancy: one possible entry minus every exit, clamped at zero.
  always_comb begin
    nexit = '0;
    for (int i = 0; i < N_DOORS; i++) nexit = nexit + SUM_W'(exit_v[i]);
    nxt = $signed(SUM_W'(COUNT)) + $signed(SUM_W'(entry)) - $signed(nexit);
    if (nxt[SUM_W-1])
      cnt_nxt = '0;
    else if (|nxt[SUM_W-2:CNT_W])
      cnt_nxt = CNT_W'(CAP);  // unreachable while grants stop at CAP
    else
      cnt_nxt = nxt[CNT_W-1:0];
  end

  // Door FSM: IDLE picks a door, GRANT holds it open until IN, timeout or T drop.
  always_ff @(posedge clk) begin
    if (CLR) begin
      st    <= IDLE;
      OPEN  <= '0;
      ptr   <= '0;
      g     <= '0;
      timer <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (grant_ok) begin
            OPEN  <= {{(N_DOORS-1){1'b0}}, 1'b1} << pick;
            g     <= pick;
            timer <= '0;
            st    <= GRANT;
          end
        end
        GRANT: begin
          if (release_door) begin
            OPEN <= '0;
            ptr  <= g_inc;
            st   <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          OPEN <= '0;
          st   <= IDLE;
        end
      endcase
    end
  end

  // Occupancy register, updated every cycle in every state.
  always_ff @(posedge clk) begin
    if (CLR) COUNT <= '0;
    else     COUNT <= cnt_nxt;
  end

  // Sticky alarm on any pass-in through a door that was not open.
  always_ff @(posedge clk) begin
    if (CLR)            ALARM <= 1'b0;
    else if (|bypass_v) ALARM <= 1'b1;
  end

endmodule
